mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
Main control unit for the multicycle RV32I-subset processor. It sequences the shared datapath (PC, unified instruction/data memory, IR, register file, ALU) through fetch, decode, execute, memory and writeback steps, one state per clock. It waits on a memory ready handshake, traps on unsupported opcodes, and counts retired instructions for debug display.

Parameters:
MEM_HANDSHAKE, 1, when 1 the FETCH/MEMREAD/MEMWRITE states wait on mem_ready; when 0, mem_ready is treated as constant 1
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
opcode  in  7  IR[6:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle (level)
pc_write  out  1  PC load enable
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  IR and OldPC load enable
result_src  out  2  00 = ALUOut, 01 = MemData, 10 = ALU result
alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
alu_src_b  out  2  00 = rs2 register, 01 = ImmExt, 10 = constant 4
alu_op  out  2  00 = add, 01 = subtract (branch), 10 = funct-decoded
reg_write  out  1  register file write enable
halted  out  1  FSM is in TRAP
state_o  out  4  current state encoding, for debug
instr_retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset: state becomes FETCH and instr_retired becomes 0 at the clock edge. While reset is high, all enables (pc_write, mem_write, ir_write, reg_write) are forced to 0 and halted=0.
- Moore decode: all outputs derive from the registered state, except pc_write, ir_write and mem_write. Those three are also qualified by zero and mem_ready as listed below. Any output not listed for a state is 0.
- Opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- State encoding, outputs and transitions:
  - FETCH (0): adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10. ir_write and pc_write are asserted only when mem_ready=1. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE (1): src_a=01, src_b=01, alu_op=00.
    - lw or sw → MEMADR
    - R-type → EXECUTER
    - I-ALU → EXECUTEI
    - beq → BEQ
    - jal → JAL
    - any other opcode → TRAP
  - MEMADR (2): src_a=10, src_b=01, alu_op=00. lw → MEMREAD; sw → MEMWRITE.
  - MEMREAD (3): adr_src=1, result_src=00. Hold until mem_ready=1, then go to MEMWB.
  - MEMWB (4): result_src=01, reg_write=1 → FETCH.
  - MEMWRITE (5): adr_src=1, result_src=00, mem_write=1. mem_write stays high for every waiting cycle. Go to FETCH when mem_ready=1.
  - EXECUTER (6): src_a=10, src_b=00, alu_op=10 → ALUWB.
  - EXECUTEI (7): src_a=10, src_b=01, alu_op=10 → ALUWB.
  - ALUWB (8): result_src=00, reg_write=1 → FETCH.
  - BEQ (9): src_a=10, src_b=00, alu_op=01, result_src=00. pc_write = zero → FETCH.
  - JAL (10): src_a=01, src_b=10, alu_op=00, result_src=00, pc_write=1 → ALUWB.
  - TRAP (11): halted=1 and all enables are 0. Only reset exits this state.
  - Encodings 12–15 are unreachable; if entered, next state is FETCH.
- Retired counter: increments by 1 on the edge leaving MEMWB, ALUWB, BEQ, or MEMWRITE (with mem_ready=1) for FETCH. It wraps modulo 2^CNT_W. A trapped instruction is not counted.
- Cycles per instruction with mem_ready always 1: lw 5, sw 4, R/I 4, beq 3, jal 4.
- A reset asserted mid-instruction (including during a memory wait) aborts the instruction. No write enable fires on that edge.

Decomposition:
- Shared package mc_pkg holds:
  - state enum (4-bit) and opcode constants
  - mux select constants for result_src, alu_src_a, alu_src_b and alu_op
- No sub-module: a single always_ff block for state and counter, plus a combinational output/next-state block.
- The funct3/funct7 ALU decoder stays in the existing separate alu_decoder. This block only drives alu_op.

Test Plan:
- reset=1 for 2 cycles, then 0 → state_o=0, all enables 0 during reset, instr_retired=0.
- lw opcode, mem_ready=1 → state sequence 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01; instr_retired=1.
- sw opcode, mem_ready low for 3 cycles in MEMWRITE → mem_write held for 4 cycles, adr_src=1 throughout, one increment of instr_retired.
- beq with zero=1, then beq with zero=0 → pc_write=1 in state 9 for the first, 0 for the second; each takes 3 cycles.
- FETCH with mem_ready=0 for 5 cycles → ir_write and pc_write stay 0 and state_o stays 0; with MEM_HANDSHAKE=0, FETCH takes 1 cycle.
- opcode 1111111 → TRAP, halted=1 and enables 0 for 20 cycles; counter preset to 2^CNT_W−1 then one R-type retired → counter wraps to 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle RV32I-subset control unit: state codes,
// opcodes and datapath mux selects.
package mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECUTER = 4'd6;
  localparam state_t S_EXECUTEI = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BEQ      = 4'd9;
  localparam state_t S_JAL      = 4'd10;
  localparam state_t S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: one state per clock through fetch/decode/execute/
// memory/writeback, with memory-ready waits, a trap state and a retire counter.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             halted,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_retired
);

  state_t state, next_state;
  logic   ready, retire;

  assign ready   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state_o = state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FETCH;
      instr_retired <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_retired <= instr_retired + CNT_W'(1);
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    next_state = S_FETCH;
    retire     = 1'b0;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    reg_write  = 1'b0;
    halted     = 1'b0;

    case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = ready;
        pc_write   = ready;
        next_state = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECUTER;
          OP_IALU:      next_state = S_EXECUTEI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        next_state = ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        retire     = ready;
        next_state = ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        pc_write  = zero;
        retire    = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        next_state = S_ALUWB;
      end
      S_TRAP: begin
        halted     = 1'b1;
        next_state = S_TRAP;
      end
      default: next_state = S_FETCH;
    endcase

    // Reset aborts the current instruction: nothing may write on that edge.
    if (reset) begin
      pc_write  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      halted    = 1'b0;
    end
  end

endmodule
